// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, control codes and legality check
package alu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // The defined codes are contiguous from 0, so one compare covers them.
    function automatic logic is_legal_ctrl(input logic [3:0] code);
        return code <= ALU_SLTU;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 64-bit integer ALU with Z/N/V/C flags
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            z,
    output logic            n,
    output logic            v,
    output logic            c
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;
    logic [5:0]    shamt;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    assign shamt = b[5:0];

    // C on subtract is the carry out of a + ~b + 1, i.e. set when no borrow.
    always_comb begin
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        case (ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_ADD: begin
                result = sum[XLEN-1:0];
                c      = sum[XLEN];
                v      = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff[XLEN-1:0];
                c      = diff[XLEN];
                v      = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_SRL:  result = a >> shamt;
            ALU_SLL:  result = a << shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
        z = (result == '0);
        n = result[XLEN-1];
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;
    int   slot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            slot = int'(ptr) + off;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (enable && !found && req[slot]) begin
                grant[slot] = 1'b1;
                grant_idx   = ID_W'(slot);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with a registered response
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]    req_ctrl,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [XLEN-1:0]         rsp_result,
    output logic                    rsp_z,
    output logic                    rsp_n,
    output logic                    rsp_v,
    output logic                    rsp_c,
    output logic                    rsp_illegal
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               can_accept;
    logic               xfer;
    logic [XLEN-1:0]    sel_a;
    logic [XLEN-1:0]    sel_b;
    logic [3:0]         sel_ctrl;
    logic [XLEN-1:0]    alu_result;
    logic               alu_z;
    logic               alu_n;
    logic               alu_v;
    logic               alu_c;

    // rst_n gates the grant so nothing is offered while reset is held.
    assign can_accept = !rsp_valid || rsp_ready;
    assign req_ready  = grant;
    assign xfer       = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (can_accept && rst_n),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_a    = req_a[int'(grant_idx)*XLEN +: XLEN];
    assign sel_b    = req_b[int'(grant_idx)*XLEN +: XLEN];
    assign sel_ctrl = req_ctrl[int'(grant_idx)*4 +: 4];
    assign ptr_next = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    alu u_alu (
        .a      (sel_a),
        .b      (sel_b),
        .ctrl   (sel_ctrl),
        .result (alu_result),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v),
        .c      (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_z       <= 1'b0;
            rsp_n       <= 1'b0;
            rsp_v       <= 1'b0;
            rsp_c       <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (xfer) begin
            ptr         <= ptr_next;
            rsp_valid   <= 1'b1;
            rsp_id      <= grant_idx;
            rsp_result  <= alu_result;
            rsp_z       <= alu_z;
            rsp_n       <= alu_n;
            rsp_v       <= alu_v;
            rsp_c       <= alu_c;
            rsp_illegal <= !is_legal_ctrl(sel_ctrl);
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_ctrl;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [0:0]   rsp_id;
    logic [63:0]  rsp_result;
    logic         rsp_z;
    logic         rsp_n;
    logic         rsp_v;
    logic         rsp_c;
    logic         rsp_illegal;
    logic [6:0]   st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // {valid, id, z, n, v, c, illegal}
    assign st = {rsp_valid, rsp_id, rsp_z, rsp_n, rsp_v, rsp_c, rsp_illegal};

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_z       (rsp_z),
        .rsp_n       (rsp_n),
        .rsp_v       (rsp_v),
        .rsp_c       (rsp_c),
        .rsp_illegal (rsp_illegal)
    );

    task automatic drive(input int i, input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl);
        req_a[i*64 +: 64]  = a;
        req_b[i*64 +: 64]  = b;
        req_ctrl[i*4 +: 4] = ctrl;
        req_valid[i]       = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (st !== 7'b0) begin errors++; $display("FAIL reset_state: got %b expected %b", st, 7'b0); end
        checks++;
        if (rsp_result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        drive(0, 64'd5, 64'd7, ALU_ADD);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (st !== 7'b1000000) begin errors++; $display("FAIL single_state: got %b expected %b", st, 7'b1000000); end
        checks++;
        if (rsp_result !== 64'd12) begin errors++; $display("FAIL single_result: got %h expected %h", rsp_result, 64'd12); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        drive(1, 64'h1234, 64'h5, 4'b1111);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL illegal_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (st !== 7'b1110001) begin errors++; $display("FAIL illegal_state: got %b expected %b", st, 7'b1110001); end
        checks++;
        if (rsp_result !== 64'h0) begin errors++; $display("FAIL illegal_result: got %h expected 0", rsp_result); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready;
        logic [6:0]  exp_st;
        logic [63:0] exp_res;
        @(posedge clk); #1;
        drive(0, 64'd3, 64'd3, ALU_SUB);
        drive(1, 64'd1, 64'd2, ALU_SLTU);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_ready) begin errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
            if (k > 0) begin
                exp_st  = ((k - 1) % 2 == 0) ? 7'b1010010 : 7'b1100000;
                exp_res = ((k - 1) % 2 == 0) ? 64'd0 : 64'd1;
                checks++;
                if (st !== exp_st) begin errors++; $display("FAIL contention_state[%0d]: got %b expected %b", k, st, exp_st); end
                checks++;
                if (rsp_result !== exp_res) begin errors++; $display("FAIL contention_result[%0d]: got %h expected %h", k, rsp_result, exp_res); end
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (st !== 7'b1100000) begin errors++; $display("FAIL contention_last_state: got %b expected %b", st, 7'b1100000); end
        checks++;
        if (rsp_result !== 64'd1) begin errors++; $display("FAIL contention_last_result: got %h expected 1", rsp_result); end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(0, 64'hF0, 64'h0F, ALU_XOR);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        drive(0, 64'h100, 64'h1, ALU_OR);
        drive(1, 64'hFF, 64'h0F, ALU_AND);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (st !== 7'b1000000) begin errors++; $display("FAIL bp_hold_state[%0d]: got %b expected %b", k, st, 7'b1000000); end
            checks++;
            if (rsp_result !== 64'hFF) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h expected ff", k, rsp_result); end
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b expected 00", k, req_ready); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready: got %b expected 10", req_ready); end
        checks++;
        if (rsp_result !== 64'hFF) begin errors++; $display("FAIL bp_release_result: got %h expected ff", rsp_result); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (st !== 7'b1100000) begin errors++; $display("FAIL bp_refill1_state: got %b expected %b", st, 7'b1100000); end
        checks++;
        if (rsp_result !== 64'h0F) begin errors++; $display("FAIL bp_refill1_result: got %h expected 0f", rsp_result); end
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_refill1_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (st !== 7'b1000000) begin errors++; $display("FAIL bp_refill0_state: got %b expected %b", st, 7'b1000000); end
        checks++;
        if (rsp_result !== 64'h101) begin errors++; $display("FAIL bp_refill0_result: got %h expected 101", rsp_result); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_flags();
        @(posedge clk); #1;
        drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL flags_add_ready: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive(0, 64'd0, 64'd1, ALU_SUB);
        @(negedge clk);
        checks++;
        if (st !== 7'b1101100) begin errors++; $display("FAIL flags_add_state: got %b expected %b", st, 7'b1101100); end
        checks++;
        if (rsp_result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL flags_add_result: got %h expected 8000000000000000", rsp_result); end
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL flags_sub_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (st !== 7'b1001000) begin errors++; $display("FAIL flags_sub_state: got %b expected %b", st, 7'b1001000); end
        checks++;
        if (rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flags_sub_result: got %h expected ffffffffffffffff", rsp_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(0, 64'd9, 64'd4, ALU_SUB);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        drive(1, 64'd1, 64'd1, ALU_ADD);
        @(negedge clk);
        checks++;
        if (st !== 7'b1000010) begin errors++; $display("FAIL midrst_pending_state: got %b expected %b", st, 7'b1000010); end
        checks++;
        if (rsp_result !== 64'd5) begin errors++; $display("FAIL midrst_pending_result: got %h expected 5", rsp_result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0) begin errors++; $display("FAIL midrst_cleared_state: got %b expected %b", st, 7'b0); end
        checks++;
        if (rsp_result !== 64'h0) begin errors++; $display("FAIL midrst_cleared_result: got %h expected 0", rsp_result); end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready_low: got %b expected 00", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_contention();
        test_backpressure();
        test_flags();
        test_mid_reset();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit integer ALU (existing `alu` module, combinational, with result and Z/N/V/C flags) between NUM_REQ requesters, e.g. the execute stage and the branch/address unit.
- Round-robin arbitration with a valid/ready handshake on every request port.
- Response port carries a single-entry registered output stage with the granted requester's ID.
- Sits between the issue logic and the shared ALU, where the ALU used to be wired directly to a single client.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*64  operand A per requester; slot i is bits [64i+63:64i].
- req_b  input  NUM_REQ*64  operand B per requester; same packing.
- req_ctrl  input  NUM_REQ*4  ALU control code per requester; slot i is bits [4i+3:4i].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_result  output  64  ALU result.
- rsp_z / rsp_n / rsp_v / rsp_c  output  1 each  ALU flags.
- rsp_illegal  output  1  control code was not one of the ten defined codes.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_id=0, rsp_result=0, all flags=0, rsp_illegal=0.
  - RR pointer=0.
  - req_ready=0 while rst_n is low.
- Control codes: AND 0000, OR 0001, ADD 0010, SRL 0011, XOR 0100, SLL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
  - Any other code: result 0, Z=1, N=V=C=0, rsp_illegal=1.
- Slot free condition: `can_accept = !rsp_valid || rsp_ready`.
- Grant selection:
  - When can_accept=1 and any req_valid is high, exactly one req_ready bit asserts combinationally in the same cycle.
  - The granted requester is the first valid one at or after the RR pointer, wrapping from NUM_REQ-1 back to 0.
  - No req_valid high: req_ready=0.
  - can_accept=0: req_ready=0.
- Transfer: a transfer occurs when req_valid[i] and req_ready[i] are both high.
  - The selected operands drive the ALU combinationally.
  - The ALU outputs, the ID and the illegal bit are registered at that edge.
  - rsp_valid=1 on the next cycle, giving a latency of 1 cycle.
- Pointer update: after a transfer, pointer = granted index + 1 (mod NUM_REQ). No transfer: pointer holds.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- Throughput: 1 operation/cycle while rsp_ready=1.
- Response pop and refill: rsp_valid drops to 0 after rsp_valid&&rsp_ready with no new transfer.
  - Simultaneous pop and new transfer: the register reloads and rsp_valid stays 1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and req_ready=0.
- Requester rules:
  - Once req_valid[i] is high, it stays high with a stable payload until req_ready[i].
  - The arbiter must not depend on this rule for correctness of the transfer it makes.
- Grant is not sticky: a requester dropping req_valid before its grant is simply skipped.
- Reset mid-operation: the pending response is discarded. After release, the first grant goes to the lowest-index valid requester.
- No internal queueing beyond the single output register. Nothing is lost or duplicated: each transfer yields exactly one response.

Decomposition:
- Package alu_pkg:
  - XLEN=64.
  - ALU control-code localparams ALU_AND..ALU_SLTU (values above).
  - Function is_legal_ctrl(code).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index; purely combinational.
  - The pointer register lives in alu_arbiter.
- Instantiate the existing `alu` once; do not duplicate its datapath.

Test Plan:
- Reset: assert rst_n=0 mid-stream with rsp_valid=1 → rsp_valid=0 and req_ready=0 immediately; after release, req_valid=2'b11 grants req 0 first.
- Single op: req0 ADD a=5, b=7, rsp_ready=1 → req_ready=2'b01 same cycle; next cycle rsp_valid=1, id=0, result=12, Z=N=V=C=0.
- Contention: both valid every cycle with req0 SUB 3-3 and req1 SLTU 1,2 → grants alternate 0,1,0,1.
  - Responses alternate result=0 with Z=1 and result=1 with Z=0.
  - One response per cycle.
- Backpressure: response pending, rsp_ready=0 for 3 cycles → rsp_* stable and req_ready=0 throughout.
  - Cycle rsp_ready=1: the next grant issues the same cycle and rsp_valid stays 1.
- Overflow/flags: ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → result 0x8000_0000_0000_0000, N=1, V=1, C=0.
  - SUB 0-1 → 0xFFFF_FFFF_FFFF_FFFF, N=1, C=0.
- Illegal code: req1 ctrl=4'b1111 → result 0, Z=1, rsp_illegal=1, id=1; the pointer still advances to 0.
